// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with pc + imm target
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int PIPE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_inst[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100: begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec_fmt = FMT_I;
        end
        5'b01000: begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
          dec_fmt = FMT_S;
        end
        5'b11000: begin
          imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
          dec_fmt = FMT_B;
        end
        5'b01101, 5'b00101: begin
          imm32   = {in_inst[31:12], 12'b0};
          dec_fmt = FMT_U;
        end
        5'b11011: begin
          imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
          dec_fmt = FMT_J;
        end
        5'b01100: begin
          dec_fmt = FMT_R;
        end
        default: begin
          dec_ill = 1'b1;
        end
      endcase
    end
  end

  // The 32-bit immediate already carries bit 31 as its sign; widen it for RV64.
  assign dec_imm = XLEN'($signed(imm32));

  if (PIPE == 2) begin : g_pipe2
    logic            s1_v, s2_v, s1_ill, s2_ill, s1_rdy, s2_rdy;
    logic [2:0]      s1_fmt, s2_fmt;
    logic [XLEN-1:0] s1_pc, s1_imm, s2_pc, s2_imm, s2_tgt;

    assign s2_rdy = !s2_v || out_ready;
    assign s1_rdy = !s1_v || s2_rdy;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v   <= 1'b0;
        s2_v   <= 1'b0;
        s1_ill <= 1'b0;
        s2_ill <= 1'b0;
        s1_fmt <= '0;
        s2_fmt <= '0;
        s1_pc  <= '0;
        s1_imm <= '0;
        s2_pc  <= '0;
        s2_imm <= '0;
        s2_tgt <= '0;
      end else begin
        if (flush) begin
          s1_v <= 1'b0;
          s2_v <= 1'b0;
        end else begin
          if (s1_rdy) s1_v <= in_valid;
          if (s2_rdy) s2_v <= s1_v;
        end
        if (s1_rdy && in_valid) begin
          s1_pc  <= in_pc;
          s1_imm <= dec_imm;
          s1_fmt <= dec_fmt;
          s1_ill <= dec_ill;
        end
        // The adder sits in stage 2 so decode and carry chain are split across cycles.
        if (s2_rdy && s1_v) begin
          s2_pc  <= s1_pc;
          s2_imm <= s1_imm;
          s2_fmt <= s1_fmt;
          s2_ill <= s1_ill;
          s2_tgt <= s1_pc + s1_imm;
        end
      end
    end

    assign in_ready    = s1_rdy;
    assign out_valid   = s2_v;
    assign out_imm     = s2_imm;
    assign out_target  = s2_tgt;
    assign out_pc      = s2_pc;
    assign out_fmt     = s2_fmt;
    assign out_illegal = s2_ill;
  end else begin : g_pipe1
    logic            s_v, s_ill;
    logic [2:0]      s_fmt;
    logic [XLEN-1:0] s_pc, s_imm, s_tgt;

    assign in_ready = !s_v || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        s_v   <= 1'b0;
        s_ill <= 1'b0;
        s_fmt <= '0;
        s_pc  <= '0;
        s_imm <= '0;
        s_tgt <= '0;
      end else begin
        if (flush) s_v <= 1'b0;
        else if (in_ready) s_v <= in_valid;
        if (in_ready && in_valid) begin
          s_pc  <= in_pc;
          s_imm <= dec_imm;
          s_fmt <= dec_fmt;
          s_ill <= dec_ill;
          s_tgt <= in_pc + dec_imm;
        end
      end
    end

    assign out_valid   = s_v;
    assign out_imm     = s_imm;
    assign out_target  = s_tgt;
    assign out_pc      = s_pc;
    assign out_fmt     = s_fmt;
    assign out_illegal = s_ill;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe (XLEN=32/PIPE=1 and XLEN=64/PIPE=2 instances)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fl_a, iv_a, ir_a, ov_a, or_a, ill_a;
  logic [31:0] inst_a, pc_a, imm_a, tgt_a, opc_a;
  logic [2:0] fmt_a;
  logic fl_b, iv_b, ir_b, ov_b, or_b, ill_b;
  logic [31:0] inst_b;
  logic [63:0] pc_b, imm_b, tgt_b, opc_b;
  logic [2:0] fmt_b;

  imm_gen_pipe #(.XLEN(32), .PIPE(1)) dut_a (
    .clk(clk), .rst(rst), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_inst(inst_a), .in_pc(pc_a), .out_valid(ov_a), .out_ready(or_a),
    .out_imm(imm_a), .out_target(tgt_a), .out_pc(opc_a), .out_fmt(fmt_a),
    .out_illegal(ill_a));

  imm_gen_pipe #(.XLEN(64), .PIPE(2)) dut_b (
    .clk(clk), .rst(rst), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_inst(inst_b), .in_pc(pc_b), .out_valid(ov_b), .out_ready(or_b),
    .out_imm(imm_b), .out_target(tgt_b), .out_pc(opc_b), .out_fmt(fmt_b),
    .out_illegal(ill_b));

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
    int          acc;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit en = 1'b0;
  logic [31:0] bp_list [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates built from signed arithmetic on the whole word.
  function automatic item_t ref_item(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    item_t it;
    longint s, t, imm;
    logic [63:0] mask;
    s = longint'($signed(inst));
    imm = 0;
    t = 0;
    it.fmt = 3'd0;
    it.ill = 1'b0;
    if (inst[1:0] != 2'b11) it.ill = 1'b1;
    else begin
      case (inst[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100: begin
          it.fmt = 3'd1; imm = s >>> 20;
        end
        5'b01000: begin
          it.fmt = 3'd2; t = s >>> 25; imm = t * 32 + longint'(inst[11:7]);
        end
        5'b11000: begin
          it.fmt = 3'd3; t = s >>> 31;
          imm = t * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        end
        5'b01101, 5'b00101: begin
          it.fmt = 3'd4; t = s >>> 12; imm = t * 4096;
        end
        5'b11011: begin
          it.fmt = 3'd5; t = s >>> 31;
          imm = t * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        end
        5'b01100: it.fmt = 3'd0;
        default: it.ill = 1'b1;
      endcase
    end
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    it.imm = 64'(imm) & mask;
    it.pc  = pc & mask;
    it.tgt = (pc + 64'(imm)) & mask;
    it.acc = 0;
    return it;
  endfunction

  // Scoreboard step at the negedge: check outputs against the oldest bundle,
  // then apply the handshakes that take effect at the next rising edge.
  task automatic mon(input int d, input int pipe, input int xlen, input string p,
                     input logic iv, input logic ir, input logic fl, input logic ov, input logic ordy,
                     input logic [63:0] imm, input logic [63:0] tgt, input logic [63:0] pc,
                     input logic [2:0] fmt, input logic ill, input logic [31:0] inst, input logic [63:0] ipc);
    item_t wq[$];
    item_t it;
    logic exp_ov, exp_ir;
    if (d == 0) wq = q0; else wq = q1;
    exp_ov = (wq.size() > 0) && (cyc >= wq[0].acc + pipe - 1);
    exp_ir = !(wq.size() == pipe && !ordy);
    chk({p, "out_valid"}, {63'd0, ov}, {63'd0, exp_ov});
    chk({p, "in_ready"}, {63'd0, ir}, {63'd0, exp_ir});
    if (exp_ov && ov === 1'b1) begin
      chk({p, "out_imm"}, imm, wq[0].imm);
      chk({p, "out_target"}, tgt, wq[0].tgt);
      chk({p, "out_pc"}, pc, wq[0].pc);
      chk({p, "out_fmt"}, {61'd0, fmt}, {61'd0, wq[0].fmt});
      chk({p, "out_illegal"}, {63'd0, ill}, {63'd0, wq[0].ill});
    end
    if (rst) wq.delete();
    else begin
      if (ov === 1'b1 && ordy && wq.size() > 0) void'(wq.pop_front());
      if (fl) wq.delete();
      else if (iv && ir === 1'b1) begin
        it = ref_item(inst, ipc, xlen);
        it.acc = cyc + 1;
        wq.push_back(it);
      end
    end
    if (d == 0) q0 = wq; else q1 = wq;
  endtask

  always @(negedge clk) begin
    if (en) begin
      mon(0, 1, 32, "a.", iv_a, ir_a, fl_a, ov_a, or_a, {32'd0, imm_a}, {32'd0, tgt_a},
          {32'd0, opc_a}, fmt_a, ill_a, inst_a, {32'd0, pc_a});
      mon(1, 2, 64, "b.", iv_b, ir_b, fl_b, ov_b, or_b, imm_b, tgt_b, opc_b, fmt_b, ill_b,
          inst_b, pc_b);
    end
  end

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    logic [4:0] op;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: op = 5'b00000;  1: op = 5'b00100;  2: op = 5'b11001;  3: op = 5'b00011;
      4: op = 5'b11100;  5: op = 5'b01000;  6: op = 5'b11000;  7: op = 5'b01101;
      8: op = 5'b00101;  9: op = 5'b11011;  10: op = 5'b01100; default: op = 5'b10110;
    endcase
    if ($urandom_range(0, 7) != 0) r[6:0] = {op, 2'b11};
    return r;
  endfunction

  task automatic send_a(input logic [31:0] inst, input logic [31:0] pc);
    @(posedge clk); #1;
    iv_a = 1'b1; inst_a = inst; pc_a = pc; or_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_b(input logic [31:0] inst, input logic [63:0] pc, input string tag);
    @(posedge clk); #1;
    iv_b = 1'b1; inst_b = inst; pc_b = pc; or_b = 1'b1;
    @(posedge clk); #1;
    iv_b = 1'b0;
    @(negedge clk);
    chk({tag, ".valid_early"}, {63'd0, ov_b}, 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, {63'd0, ov_b}, 64'd1);
  endtask

  initial begin
    int idx, acc_n, pops;
    rst = 1'b1;
    fl_a = 1'b0; iv_a = 1'b0; or_a = 1'b1; inst_a = '0; pc_a = '0;
    fl_b = 1'b0; iv_b = 1'b0; or_b = 1'b1; inst_b = '0; pc_b = '0;
    bp_list[0] = 32'h00001037; bp_list[1] = 32'h00002037;
    bp_list[2] = 32'h00003037; bp_list[3] = 32'h00004037;

    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.a.valid", {63'd0, ov_a}, 64'd0);
    chk("rst.a.imm", {32'd0, imm_a}, 64'd0);
    chk("rst.a.target", {32'd0, tgt_a}, 64'd0);
    chk("rst.a.pc", {32'd0, opc_a}, 64'd0);
    chk("rst.a.fmt", {61'd0, fmt_a}, 64'd0);
    chk("rst.a.illegal", {63'd0, ill_a}, 64'd0);
    chk("rst.a.in_ready", {63'd0, ir_a}, 64'd1);
    chk("rst.b.valid", {63'd0, ov_b}, 64'd0);
    chk("rst.b.imm", imm_b, 64'd0);
    chk("rst.b.target", tgt_b, 64'd0);
    chk("rst.b.pc", opc_b, 64'd0);
    chk("rst.b.fmt", {61'd0, fmt_b}, 64'd0);
    chk("rst.b.illegal", {63'd0, ill_b}, 64'd0);
    chk("rst.b.in_ready", {63'd0, ir_b}, 64'd1);

    send_a(32'hFE000CE3, 32'h100);
    chk("beq.valid", {63'd0, ov_a}, 64'd1);
    chk("beq.imm", {32'd0, imm_a}, 64'hFFFFFFF8);
    chk("beq.target", {32'd0, tgt_a}, 64'h000000F8);
    chk("beq.fmt", {61'd0, fmt_a}, 64'd3);
    chk("beq.illegal", {63'd0, ill_a}, 64'd0);
    send_a(32'h123450B7, 32'h0);
    chk("lui.imm", {32'd0, imm_a}, 64'h12345000);
    chk("lui.fmt", {61'd0, fmt_a}, 64'd4);
    send_a(32'hFE20AE23, 32'h0);
    chk("sw.imm", {32'd0, imm_a}, 64'hFFFFFFFC);
    chk("sw.fmt", {61'd0, fmt_a}, 64'd2);
    send_a(32'h001000EF, 32'h200);
    chk("jal.imm", {32'd0, imm_a}, 64'h00000800);
    chk("jal.target", {32'd0, tgt_a}, 64'h00000A00);
    chk("jal.fmt", {61'd0, fmt_a}, 64'd5);
    send_a(32'h00000000, 32'h300);
    chk("zero.illegal", {63'd0, ill_a}, 64'd1);
    chk("zero.imm", {32'd0, imm_a}, 64'd0);
    chk("zero.fmt", {61'd0, fmt_a}, 64'd0);
    send_a(32'hFFFFFFFF, 32'h304);
    chk("op7f.illegal", {63'd0, ill_a}, 64'd1);
    chk("op7f.imm", {32'd0, imm_a}, 64'd0);
    chk("op7f.fmt", {61'd0, fmt_a}, 64'd0);

    send_b(32'hFFF00093, 64'h1000, "addi64");
    chk("addi64.imm", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi64.fmt", {61'd0, fmt_b}, 64'd1);
    send_b(32'h800000B7, 64'h1000, "lui64");
    chk("lui64.imm", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui64.target", tgt_b, 64'hFFFF_FFFF_8000_1000);
    chk("lui64.fmt", {61'd0, fmt_b}, 64'd4);
    repeat (3) @(posedge clk);

    idx = 0; acc_n = 0; pops = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      iv_b = (idx < 4);
      inst_b = bp_list[(idx < 4) ? idx : 0];
      pc_b = 64'h4000 + 64'(idx * 4);
      or_b = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 2) begin
        chk("bp.in_ready_low", {63'd0, ir_b}, 64'd0);
        chk("bp.accepts_before_stall", 64'(acc_n), 64'd2);
      end
      if (iv_b && ir_b) begin idx++; acc_n++; end
      if (ov_b && or_b) pops++;
    end
    chk("bp.accepts", 64'(acc_n), 64'd4);
    chk("bp.pops", 64'(pops), 64'd4);

    @(posedge clk); #1;
    iv_b = 1'b1; or_b = 1'b0; inst_b = 32'h00011037; pc_b = 64'h5000;
    @(posedge clk); #1;
    inst_b = 32'h00022037; pc_b = 64'h5004;
    @(posedge clk); #1;
    inst_b = 32'h00033037; pc_b = 64'h5008; fl_b = 1'b1; or_b = 1'b1;
    @(negedge clk);
    chk("fl.full_valid", {63'd0, ov_b}, 64'd1);
    @(posedge clk); #1;
    fl_b = 1'b0; iv_b = 1'b0;
    @(negedge clk);
    chk("fl.valid", {63'd0, ov_b}, 64'd0);
    chk("fl.in_ready", {63'd0, ir_b}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fl.no_emit", {63'd0, ov_b}, 64'd0);
    end

    @(posedge clk); #1;
    iv_a = 1'b1; inst_a = 32'hFFF00093; pc_a = 32'h700; or_a = 1'b0;
    iv_b = 1'b1; inst_b = 32'hFFF00093; pc_b = 64'h700; or_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid.a.busy", {63'd0, ov_a}, 64'd1);
    chk("mid.b.busy", {63'd0, ov_b}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid.a.valid", {63'd0, ov_a}, 64'd0);
    chk("mid.a.imm", {32'd0, imm_a}, 64'd0);
    chk("mid.a.target", {32'd0, tgt_a}, 64'd0);
    chk("mid.b.valid", {63'd0, ov_b}, 64'd0);
    chk("mid.b.imm", imm_b, 64'd0);
    chk("mid.b.target", tgt_b, 64'd0);
    chk("mid.b.pc", opc_b, 64'd0);
    chk("mid.b.fmt", {61'd0, fmt_b}, 64'd0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 499) == 0);
      iv_a = ($urandom_range(0, 3) != 0);
      or_a = ($urandom_range(0, 2) != 0);
      fl_a = ($urandom_range(0, 39) == 0);
      inst_a = rnd_inst();
      pc_a = $urandom;
      iv_b = ($urandom_range(0, 3) != 0);
      or_b = ($urandom_range(0, 2) != 0);
      fl_b = ($urandom_range(0, 39) == 0);
      inst_b = rnd_inst();
      pc_b = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0; fl_a = 1'b0; fl_b = 1'b0; or_a = 1'b1; or_b = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator and PC-relative target unit for the RV32I/RV64I decode path. It accepts a fetched instruction and its PC over a valid/ready handshake. It produces the sign-extended immediate, the immediate format, an illegal-encoding flag and `pc + imm` after a configurable 1- or 2-cycle latency, with back-pressure and flush support. It sits between the IF/ID register and the register-file read/hazard logic. It replaces the purely combinational immediate decode.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `PIPE`, 1: latency in cycles; legal values 1 or 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous pipeline kill, from branch resolution.
- `in_valid` in 1: `in_inst`/`in_pc` are valid this cycle.
- `in_ready` out 1: block accepts the input this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: instruction PC.
- `out_valid` out 1: output bundle is valid.
- `out_ready` in 1: consumer takes the bundle this cycle.
- `out_imm` out XLEN: sign-extended immediate.
- `out_target` out XLEN: `out_pc + out_imm`, modulo 2^XLEN.
- `out_pc` out XLEN: PC passthrough.
- `out_fmt` out 3: 0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J.
- `out_illegal` out 1: unsupported encoding.

## Operation
- Opcode decode uses `inst[6:2]`. Any encoding with `inst[1:0]` != 2'b11 is illegal.
- Immediate formats (sext = sign-extend bit 31 to XLEN):
  - I-format (Load 00000, Arith_I 00100, JALR 11001, FENCE 00011, SYSTEM 11100): sext `inst[31:20]`.
  - S-format (Store 01000): sext `{inst[31:25], inst[11:7]}`.
  - B-format (Branch 11000): sext `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - U-format (LUI 01101, AUIPC 00101): sext `{inst[31:12], 12'b0}`. Sign extension matters for XLEN=64.
  - J-format (JAL 11011): sext `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
  - R-format (Arith_R 01100): imm = 0, fmt = 0.
- Any other opcode, or `inst[1:0]` != 11, gives imm = 0, fmt = 0, illegal = 1. Illegal bundles still flow through the pipe; they are not dropped.
- `out_target` is always computed, including for non-PC-relative formats. The adder wraps silently.
- PIPE=1:
  - One register stage holds the decoded immediate and the sum.
- PIPE=2:
  - Stage 1 registers pc, imm, fmt and illegal.
  - Stage 2 registers the sum and passes the other fields through.
- Each stage has a valid bit. A stage loads when its upstream is valid and the stage is ready.
- A stage is ready when `!valid || downstream_ready`. `in_ready` is stage 1's ready and is a combinational function of `out_ready` and the valid bits.
- Output data is held stable while `out_valid && !out_ready`.
- Flush clears every valid bit at the next edge. Flush wins over a simultaneous accept: the input presented in the flush cycle is discarded.
- Data registers are don't-care while their valid bit is 0. They are still reset to 0.

## Timing
- Reset: all valid bits are 0 and all data registers are 0. So `out_valid`=0, `out_imm`=0, `out_target`=0, `out_pc`=0, `out_fmt`=0, `out_illegal`=0.
- `in_ready` is 1 in the cycle after reset deasserts. Reset mid-stream discards all in-flight bundles.
- Latency:
  - An input accepted at edge N appears with `out_valid`=1 after edge N+PIPE-1. The first visible cycle is N+PIPE.
  - Full throughput is 1 bundle/cycle while `out_ready`=1.
- Back-pressure:
  - `in_ready` drops only when every stage is valid and `out_ready`=0.
  - Capacity is PIPE bundles. There is no loss or duplication, and order is preserved.
- Simultaneous events:
  - Output handshake and input accept in the same cycle with a full pipe: both occur and the pipe stays full.
  - `flush` together with `out_ready`=1: the current output counts as consumed, and nothing new becomes valid.
- `rst` overrides `flush`.

## Test plan
- Branch, PIPE=1, XLEN=32: `in_inst`=0xFE000CE3 (beq -8), `in_pc`=0x100 → one cycle later `out_imm`=0xFFFFFFF8, `out_target`=0x000000F8, `out_fmt`=3, `out_illegal`=0.
- Immediate formats: lui 0x123450B7 → imm 0x12345000, fmt 4. sw 0xFE20AE23 → imm 0xFFFFFFFC, fmt 2. jal 0x001000EF at pc 0x200 → imm 0x00000800, target 0x00000A00, fmt 5.
- XLEN=64, PIPE=2: addi -1 (0xFFF00093) → imm 0xFFFFFFFFFFFFFFFF, fmt 1, valid 2 cycles after accept. lui 0x800000B7 → imm 0xFFFFFFFF80000000.
- Back-pressure, PIPE=2: stream 4 bundles with `out_ready` low for 3 cycles starting at the first output → `in_ready` falls after 2 accepts, all 4 emerge in order, no duplicates.
- Flush: pipe full plus `in_valid`=1 and `flush`=1 in the same cycle → `out_valid`=0 the next cycle, `in_ready`=1, the flushed input is never emitted.
- Illegal encodings: 0x00000000 and opcode 1111111 → `out_illegal`=1, `out_imm`=0, `out_fmt`=0. Assert `rst` mid-stream → all outputs 0 next cycle.
